// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS constants, opcodes and instruction-fetch FSM state encoding
package mips_pkg;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// instr_mem: 2**ADDR_W x 32 program memory, synchronous write, asynchronous read
module instr_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Program load port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_instr_fetch.sv
// mips_instr_fetch: PC, next-PC select and run control feeding instructions to the datapath
// Optional retired-instruction counter enabled by defining IFETCH_PERF_CNT_EN.
module mips_instr_fetch
    import mips_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic              en,
    input  logic              branch_taken,
    input  logic [15:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    output logic [31:0]       instruction,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              running,
    output logic              halted,
    output logic [31:0]       retired_count
);

    fetch_state_t state;
    logic [31:0]  word;
    logic [31:0]  jump_pc;
    logic [31:0]  branch_pc;
    logic [31:0]  next_pc;
    logic         is_halt;

    instr_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (load_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (word)
    );

    assign pc_plus4    = pc + 32'd4;
    assign jump_pc     = {pc_plus4[31:28], jump_target, 2'b00};
    assign branch_pc   = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign next_pc     = jump ? jump_pc : branch_taken ? branch_pc : pc_plus4;
    assign is_halt     = word == HALT_WORD;
    assign instruction = state == FS_RUN ? word : NOP_WORD;

    // Run-control FSM and PC; the halt word freezes the PC on its own address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FS_IDLE;
            pc      <= RESET_PC;
            running <= 1'b0;
            halted  <= 1'b0;
        end else if (state != FS_RUN) begin
            if (start) begin
                state   <= FS_RUN;
                pc      <= RESET_PC;
                running <= 1'b1;
                halted  <= 1'b0;
            end
        end else if (en) begin
            if (is_halt) begin
                state   <= FS_HALT;
                running <= 1'b0;
                halted  <= 1'b1;
            end else begin
                pc <= next_pc;
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Count every word that advanced the PC in RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retired_count <= 32'h0;
        else if (state == FS_RUN && en && !is_halt) retired_count <= retired_count + 32'd1;
    end
`else
    assign retired_count = 32'h0;
`endif

endmodule

// File: tb/tb_mips_instr_fetch.sv
// tb_mips_instr_fetch: scoreboard bench for program load, sequential/branch/jump fetch and run control
`timescale 1ns/1ps
module tb_mips_instr_fetch;

`ifdef IFETCH_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_we = 1'b0;
    logic [7:0]  load_addr = 8'h0;
    logic [31:0] load_data = 32'h0;
    logic        start = 1'b0;
    logic        en = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'h0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        running;
    logic        halted;
    logic [31:0] retired_count;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    int          n_run = 0;
    int          n_fail = 0;
    logic [31:0] cnt_m = 32'h0;
    logic [31:0] mem_m [256];
    logic [31:0] prog [4] = '{32'h2001000A, 32'h20020014, 32'h00221820, 32'h00412022};

    mips_instr_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .load_we       (load_we),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .start         (start),
        .en            (en),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .instruction   (instruction),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .running       (running),
        .halted        (halted),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [31:0] data);
        load_we   = 1'b1;
        load_addr = addr;
        load_data = data;
        mem_m[addr] = data;
        tick();
        load_we = 1'b0;
    endtask

    function automatic logic [31:0] exp_cnt();
        return CNT_EN ? cnt_m : 32'h0;
    endfunction

    // Push the expected fetch, clock once, then pop and compare against the DUT
    task automatic step(input string tag, input logic [31:0] exp_pc, input logic adv);
        exp_t e;
        e.tag = tag;
        e.pc  = exp_pc;
        e.ins = mem_m[exp_pc[9:2]];
        sb.push_back(e);
        tick();
        if (adv) cnt_m = cnt_m + 32'd1;
        e = sb.pop_front();
        check({e.tag, "_pc"}, pc, e.pc);
        check({e.tag, "_instr"}, instruction, e.ins);
        check({e.tag, "_cnt"}, retired_count, exp_cnt());
    endtask

    initial begin
        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_running", {31'h0, running}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_cnt", retired_count, 32'h0);
        #5 reset = 1'b1;

        for (int i = 0; i < 256; i++)
            load(8'(i), i < 4 ? prog[i] : i == 4 ? 32'hFFFF_FFFF : {16'h2400, 16'(i)});
        check("idle_running", {31'h0, running}, 32'h0);
        check("idle_instr", instruction, 32'h0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_running", {31'h0, running}, 32'h1);
        check("start_pc", pc, 32'h0);
        check("start_instr", instruction, 32'h2001000A);
        en = 1'b1;
        step("seq1", 32'h04, 1'b1);
        check("seq1_word", instruction, 32'h20020014);
        step("seq2", 32'h08, 1'b1);
        check("seq2_word", instruction, 32'h00221820);
        step("seq3", 32'h0C, 1'b1);
        check("seq3_word", instruction, 32'h00412022);
        step("seq4", 32'h10, 1'b1);
        tick();
        check("halt_halted", {31'h0, halted}, 32'h1);
        check("halt_running", {31'h0, running}, 32'h0);
        check("halt_pc", pc, 32'h10);
        check("halt_instr", instruction, 32'h0);
        check("halt_cnt", retired_count, CNT_EN ? 32'd4 : 32'h0);
        tick();
        check("halt_hold_pc", pc, 32'h10);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_running", {31'h0, running}, 32'h1);
        check("restart_halted", {31'h0, halted}, 32'h0);
        check("restart_pc", pc, 32'h0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step("stall", 32'h0, 1'b0);

        load(8'h00, 32'h3402_00FF);
        check("wr_cur_instr", instruction, 32'h3402_00FF);
        check("wr_cur_pc", pc, 32'h0);

        en = 1'b1;
        step("to4", 32'h04, 1'b1);
        step("to8", 32'h08, 1'b1);
        branch_taken = 1'b1;
        branch_offset = 16'hFFFE;
        step("br_back", 32'h04, 1'b1);
        branch_taken = 1'b0;
        step("to8b", 32'h08, 1'b1);
        branch_taken = 1'b1;
        branch_offset = 16'h0003;
        step("br_fwd", 32'h18, 1'b1);
        branch_taken = 1'b0;

        jump = 1'b1;
        jump_target = 26'h000_0010;
        step("jmp", 32'h40, 1'b1);
        branch_taken = 1'b1;
        branch_offset = 16'h0100;
        step("jmp_pri", 32'h40, 1'b1);
        branch_taken = 1'b0;
        jump_target = 26'h000_00FF;
        step("jmp_top", 32'h3FC, 1'b1);
        jump = 1'b0;
        step("alias", 32'h400, 1'b1);
        check("alias_word", instruction, 32'h3402_00FF);
        check("alias_pc4", pc_plus4, 32'h404);

        jump = 1'b1;
        jump_target = 26'h000_0004;
        step("to10", 32'h10, 1'b1);
        jump = 1'b0;
        en = 1'b0;
        #2 reset = 1'b0;
        cnt_m = 32'h0;
        #1;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_instr", instruction, 32'h0);
        check("mid_rst_running", {31'h0, running}, 32'h0);
        check("mid_rst_cnt", retired_count, 32'h0);
        #2 reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
